// File: rtl/shiftreg_univ.sv
// Universal shift register: DEPTH stages of WIDTH bits with hold, forward/reverse shift,
// parallel load and a saturating fill count. Define SHIFTREG_ROTATE_EN to honour rot.
module shiftreg_univ #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       rot,
    input  logic [WIDTH-1:0]           sin_fwd,
    input  logic [WIDTH-1:0]           sin_rev,
    input  logic [DEPTH*WIDTH-1:0]     pin,
    output logic [DEPTH*WIDTH-1:0]     pout,
    output logic [WIDTH-1:0]           sout_fwd,
    output logic [WIDTH-1:0]           sout_rev,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       full,
    output logic                       empty
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] DEPTH_C = FW'(DEPTH);

    logic [DEPTH*WIDTH-1:0] stages_r;
    logic [DEPTH*WIDTH-1:0] stages_nxt_s;
    logic [FW-1:0]          fill_r;
    logic [FW-1:0]          fill_nxt_s;
    logic [FW-1:0]          fill_inc_s;
    logic [WIDTH-1:0]       fwd_in_s;
    logic [WIDTH-1:0]       rev_in_s;

`ifdef SHIFTREG_ROTATE_EN
    assign fwd_in_s = rot ? stages_r[(DEPTH-1)*WIDTH +: WIDTH] : sin_fwd;
    assign rev_in_s = rot ? stages_r[0 +: WIDTH] : sin_rev;
`else
    // rot is deliberately masked off so the port stays connected but inert
    assign fwd_in_s = sin_fwd | {WIDTH{rot & 1'b0}};
    assign rev_in_s = sin_rev;
`endif

    assign fill_inc_s = (fill_r == DEPTH_C) ? fill_r : (fill_r + {{(FW-1){1'b0}}, 1'b1});

    // Next-state selection by mode; en low freezes everything
    always_comb begin
        stages_nxt_s = stages_r;
        fill_nxt_s   = fill_r;
        if (en) begin
            case (mode)
                2'b00: begin
                    stages_nxt_s = stages_r;
                    fill_nxt_s   = fill_r;
                end
                2'b01: begin
                    stages_nxt_s = {stages_r[(DEPTH-1)*WIDTH-1:0], fwd_in_s};
                    fill_nxt_s   = fill_inc_s;
                end
                2'b10: begin
                    stages_nxt_s = {rev_in_s, stages_r[DEPTH*WIDTH-1:WIDTH]};
                    fill_nxt_s   = fill_inc_s;
                end
                2'b11: begin
                    stages_nxt_s = pin;
                    fill_nxt_s   = DEPTH_C;
                end
                default: begin
                    stages_nxt_s = stages_r;
                    fill_nxt_s   = fill_r;
                end
            endcase
        end else begin
            stages_nxt_s = stages_r;
            fill_nxt_s   = fill_r;
        end
    end

    // State registers with synchronous clear taking priority
    always_ff @(posedge clock) begin
        if (clear) begin
            stages_r <= {(DEPTH*WIDTH){1'b0}};
            fill_r   <= {FW{1'b0}};
        end else begin
            stages_r <= stages_nxt_s;
            fill_r   <= fill_nxt_s;
        end
    end

    assign pout     = stages_r;
    assign sout_fwd = stages_r[(DEPTH-1)*WIDTH +: WIDTH];
    assign sout_rev = stages_r[0 +: WIDTH];
    assign fill     = fill_r;
    assign full     = (fill_r == DEPTH_C);
    assign empty    = (fill_r == {FW{1'b0}});

endmodule

// File: tb/tb_shiftreg_univ.sv
// Directed self-checking bench for shiftreg_univ: one WIDTH=1/DEPTH=4 instance and
// one WIDTH=8/DEPTH=3 instance sharing a clock.
module tb_shiftreg_univ;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: WIDTH=1, DEPTH=4
    logic       a_clear, a_en, a_rot, a_sin_fwd, a_sin_rev;
    logic [1:0] a_mode;
    logic [3:0] a_pin, a_pout;
    logic       a_sout_fwd, a_sout_rev, a_full, a_empty;
    logic [2:0] a_fill;

    // Instance B: WIDTH=8, DEPTH=3
    logic        b_clear, b_en, b_rot;
    logic [1:0]  b_mode;
    logic [7:0]  b_sin_fwd, b_sin_rev, b_sout_fwd, b_sout_rev;
    logic [23:0] b_pin, b_pout;
    logic [1:0]  b_fill;
    logic        b_full, b_empty;

    shiftreg_univ #(.WIDTH(1), .DEPTH(4)) dut_a (
        .clock(clock), .clear(a_clear), .en(a_en), .mode(a_mode), .rot(a_rot),
        .sin_fwd(a_sin_fwd), .sin_rev(a_sin_rev), .pin(a_pin), .pout(a_pout),
        .sout_fwd(a_sout_fwd), .sout_rev(a_sout_rev), .fill(a_fill),
        .full(a_full), .empty(a_empty)
    );

    shiftreg_univ #(.WIDTH(8), .DEPTH(3)) dut_b (
        .clock(clock), .clear(b_clear), .en(b_en), .mode(b_mode), .rot(b_rot),
        .sin_fwd(b_sin_fwd), .sin_rev(b_sin_rev), .pin(b_pin), .pout(b_pout),
        .sout_fwd(b_sout_fwd), .sout_rev(b_sout_rev), .fill(b_fill),
        .full(b_full), .empty(b_empty)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [3:0] rot_exp [4];
        rot_exp[0] = 4'b0010;
        rot_exp[1] = 4'b0100;
        rot_exp[2] = 4'b1000;
`ifdef SHIFTREG_ROTATE_EN
        rot_exp[3] = 4'b0001;
`else
        rot_exp[3] = 4'b0000;
`endif

        a_clear = 1'b1; a_en = 1'b0; a_mode = 2'b00; a_rot = 1'b0;
        a_sin_fwd = 1'b0; a_sin_rev = 1'b0; a_pin = 4'b0000;
        b_clear = 1'b1; b_en = 1'b0; b_mode = 2'b00; b_rot = 1'b0;
        b_sin_fwd = 8'h00; b_sin_rev = 8'h00; b_pin = 24'h000000;
        step();

        // Garbage state, then clear
        a_clear = 1'b0; a_en = 1'b1; a_mode = 2'b11; a_pin = 4'b1010;
        step();
        check("load_garbage_pout", 64'(a_pout), 64'h0A);
        check("load_garbage_full", 64'(a_full), 64'h1);
        a_clear = 1'b1; a_sin_fwd = 1'b1; a_mode = 2'b01;
        step();
        check("clr_pout", 64'(a_pout), 64'h0);
        check("clr_fill", 64'(a_fill), 64'h0);
        check("clr_empty", 64'(a_empty), 64'h1);
        check("clr_full", 64'(a_full), 64'h0);
        check("clr_sout_fwd", 64'(a_sout_fwd), 64'h0);
        check("clr_sout_rev", 64'(a_sout_rev), 64'h0);
        a_clear = 1'b0; a_mode = 2'b11; a_pin = 4'b0110;
        step();
        a_clear = 1'b1; a_en = 1'b0;
        step();
        check("clr_en0_pout", 64'(a_pout), 64'h0);
        check("clr_en0_fill", 64'(a_fill), 64'h0);

        // Forward shift 1,0,1,1
        a_clear = 1'b0; a_en = 1'b1; a_mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            a_sin_fwd = (i == 1) ? 1'b0 : 1'b1;
            step();
            check("fwd_fill", 64'(a_fill), 64'(i + 1));
            check("fwd_full", 64'(a_full), (i == 3) ? 64'h1 : 64'h0);
        end
        check("fwd_pout", 64'(a_pout), 64'hB);
        check("fwd_sout_fwd", 64'(a_sout_fwd), 64'h1);
        check("fwd_sout_rev", 64'(a_sout_rev), 64'h1);
        check("fwd_empty", 64'(a_empty), 64'h0);
        a_sin_fwd = 1'b0;
        step();
        check("fwd5_fill_sat", 64'(a_fill), 64'h4);
        check("fwd5_pout", 64'(a_pout), 64'h6);
        a_mode = 2'b10; a_sin_rev = 1'b1;
        step();
        check("rev_a_pout", 64'(a_pout), 64'hB);
        check("rev_a_fill", 64'(a_fill), 64'h4);

        // B: clear already applied; load then reverse shift
        b_clear = 1'b0; b_en = 1'b1; b_mode = 2'b11; b_pin = 24'h332211;
        step();
        check("b_load_pout", 64'(b_pout), 64'h332211);
        check("b_load_fill", 64'(b_fill), 64'h3);
        check("b_load_full", 64'(b_full), 64'h1);
        b_mode = 2'b10; b_sin_rev = 8'hAA; b_pin = 24'hFFFFFF;
        step();
        check("b_rev_pout", 64'(b_pout), 64'hAA3322);
        check("b_rev_sout_rev", 64'(b_sout_rev), 64'h22);
        check("b_rev_sout_fwd", 64'(b_sout_fwd), 64'hAA);
        check("b_rev_fill", 64'(b_fill), 64'h3);

        // Hold via en=0 for five cycles, then mode 00
        b_en = 1'b0; b_mode = 2'b01; b_sin_fwd = 8'h5C;
        for (int i = 0; i < 5; i++) begin
            step();
            check("b_en0_pout", 64'(b_pout), 64'hAA3322);
        end
        check("b_en0_fill", 64'(b_fill), 64'h3);
        b_en = 1'b1; b_mode = 2'b00;
        step();
        check("b_hold_pout", 64'(b_pout), 64'hAA3322);
        check("b_hold_fill", 64'(b_fill), 64'h3);
        b_mode = 2'b01; b_sin_fwd = 8'h55;
        step();
        check("b_fwd_pout", 64'(b_pout), 64'h332255);

        // Clear mid-stream against a load request
        a_clear = 1'b1;
        step();
        a_clear = 1'b0; a_mode = 2'b01; a_sin_fwd = 1'b1;
        step();
        step();
        check("mid_fill2", 64'(a_fill), 64'h2);
        check("mid_pout2", 64'(a_pout), 64'h3);
        a_clear = 1'b1; a_mode = 2'b11; a_pin = 4'b1111;
        step();
        check("mid_clr_pout", 64'(a_pout), 64'h0);
        check("mid_clr_fill", 64'(a_fill), 64'h0);
        a_clear = 1'b0; a_mode = 2'b01; a_sin_fwd = 1'b1;
        step();
        check("mid_resume_fill", 64'(a_fill), 64'h1);
        check("mid_resume_pout", 64'(a_pout), 64'h1);
        check("mid_resume_empty", 64'(a_empty), 64'h0);

        // Rotate request with sin_fwd=0
        a_mode = 2'b11; a_pin = 4'b0001; a_rot = 1'b1;
        step();
        check("rot_load", 64'(a_pout), 64'h1);
        a_mode = 2'b01; a_sin_fwd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rot_pout", 64'(a_pout), 64'(rot_exp[i]));
        end
        check("rot_fill", 64'(a_fill), 64'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
